// File: rtl/ifm_fetch_pkg.sv
// Shared types and constants for the input-feature-map fetch controller.
package ifm_fetch_pkg;

  localparam int BURST_CODE_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    REQ,
    DATA,
    DONE
  } fetch_state_e;

endpackage

// File: rtl/ifm_fetch_ctrl_if.sv
// Read-channel and input-buffer write port bundle seen by the fetch controller.
interface ifm_fetch_ctrl_if #(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int BUF_AW = 10
);
  import ifm_fetch_pkg::*;

  logic [AW-1:0]           araddr;
  logic                    arvalid;
  logic [BURST_CODE_W-1:0] arburst;
  logic                    arready;
  logic [DW-1:0]           rdata;
  logic                    rvalid;
  logic                    rlast;
  logic [BUF_AW:0]         buf_space;
  logic                    wr_en;
  logic [BUF_AW-1:0]       wr_addr;
  logic [DW-1:0]           wr_data;

  modport master (
    output araddr, arvalid, arburst,
    input  arready, rdata, rvalid, rlast, buf_space,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    input  araddr, arvalid, arburst,
    output arready, rdata, rvalid, rlast, buf_space,
    input  wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/ifm_fetch_ctrl_burst_planner.sv
// Picks the largest power-of-two burst that fits in the remaining word count,
// capped at MAX_BURST_CODE. Purely combinational.
module burst_planner
  import ifm_fetch_pkg::*;
#(
  parameter int CNT_W          = 24,
  parameter int MAX_BURST_CODE = 4
) (
  input  logic [CNT_W-1:0]        remain,
  output logic [BURST_CODE_W-1:0] code,
  output logic [CNT_W-1:0]        len
);

  int msb;

  // Priority encoder: highest set bit wins; remain==0 never reaches the planner.
  always_comb begin
    msb = 0;
    for (int i = 0; i < CNT_W; i++) begin
      if (remain[i]) msb = i;
    end
  end

  assign code = BURST_CODE_W'((msb > MAX_BURST_CODE) ? MAX_BURST_CODE : msb);
  assign len  = CNT_W'(1) << code;

endmodule

// File: rtl/ifm_fetch_ctrl.sv
// Burst-read fetch controller: splits a word count into power-of-two read bursts and
// streams returned beats into the input buffer. Optional beat checker: FETCH_BEAT_CHECK_EN.
module ifm_fetch_ctrl
  import ifm_fetch_pkg::*;
#(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int CNT_W          = 24,
  parameter int BUF_AW         = 10,
  parameter int MAX_BURST_CODE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [CNT_W-1:0] total_words,
  output logic             busy,
  output logic             done,
  output logic             err,
  ifm_fetch_ctrl_if.master bus
);

  localparam int CMP_W = CNT_W + BUF_AW + 1;

  fetch_state_e            state_reg,    state_next;
  logic [AW-1:0]           cur_addr_reg, cur_addr_next;
  logic [CNT_W-1:0]        remain_reg,   remain_next;
  logic [CNT_W-1:0]        len_reg,      len_next;
  logic [AW-1:0]           araddr_reg,   araddr_next;
  logic [BURST_CODE_W-1:0] arburst_reg,  arburst_next;
  logic                    arvalid_reg,  arvalid_next;
  logic [BUF_AW-1:0]       wr_ptr_reg,   wr_ptr_next;
  logic [BUF_AW-1:0]       wr_addr_reg,  wr_addr_next;
  logic [DW-1:0]           wr_data_reg,  wr_data_next;
  logic                    wr_en_reg,    wr_en_next;
  logic                    busy_reg,     busy_next;
  logic                    done_reg,     done_next;

  logic [BURST_CODE_W-1:0] plan_code;
  logic [CNT_W-1:0]        plan_len;
  logic                    plan_fits, len_fits;
  logic                    start_acc, ar_hs, beat;

  burst_planner #(
    .CNT_W         (CNT_W),
    .MAX_BURST_CODE(MAX_BURST_CODE)
  ) u_planner (
    .remain(remain_reg),
    .code  (plan_code),
    .len   (plan_len)
  );

  // Zero-extend both sides so the space check never truncates either operand.
  assign plan_fits = CMP_W'(bus.buf_space) >= CMP_W'(plan_len);
  assign len_fits  = CMP_W'(bus.buf_space) >= CMP_W'(len_reg);

  assign start_acc = (state_reg == IDLE) && start;
  assign ar_hs     = (state_reg == REQ) && arvalid_reg && bus.arready;
  assign beat      = (state_reg == DATA) && bus.rvalid;

  always_comb begin
    state_next    = state_reg;
    cur_addr_next = cur_addr_reg;
    remain_next   = remain_reg;
    len_next      = len_reg;
    araddr_next   = araddr_reg;
    arburst_next  = arburst_reg;
    arvalid_next  = arvalid_reg;
    wr_ptr_next   = wr_ptr_reg;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    wr_en_next    = 1'b0;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_acc) begin
          cur_addr_next = base_addr;
          remain_next   = total_words;
          wr_ptr_next   = '0;
          wr_addr_next  = '0;
          busy_next     = 1'b1;
          state_next    = (total_words == '0) ? DONE : PLAN;
        end
      end
      PLAN: begin
        len_next     = plan_len;
        arburst_next = plan_code;
        araddr_next  = cur_addr_reg;
        arvalid_next = plan_fits;
        state_next   = REQ;
      end
      REQ: begin
        // Request is re-qualified against buffer room every cycle until accepted.
        if (ar_hs) begin
          arvalid_next  = 1'b0;
          cur_addr_next = cur_addr_reg + AW'(len_reg);
          remain_next   = remain_reg - len_reg;
          state_next    = DATA;
        end else begin
          arvalid_next  = len_fits;
        end
      end
      DATA: begin
        if (beat) begin
          wr_en_next   = 1'b1;
          wr_data_next = bus.rdata;
          wr_addr_next = wr_ptr_reg;
          wr_ptr_next  = wr_ptr_reg + BUF_AW'(1);
          if (bus.rlast) state_next = (remain_reg == '0) ? DONE : PLAN;
        end
      end
      DONE: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cur_addr_reg <= '0;
      remain_reg   <= '0;
      len_reg      <= '0;
      araddr_reg   <= '0;
      arburst_reg  <= '0;
      arvalid_reg  <= 1'b0;
      wr_ptr_reg   <= '0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      wr_en_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_addr_reg <= cur_addr_next;
      remain_reg   <= remain_next;
      len_reg      <= len_next;
      araddr_reg   <= araddr_next;
      arburst_reg  <= arburst_next;
      arvalid_reg  <= arvalid_next;
      wr_ptr_reg   <= wr_ptr_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      wr_en_reg    <= wr_en_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign bus.araddr  = araddr_reg;
  assign bus.arburst = arburst_reg;
  assign bus.arvalid = arvalid_reg;
  assign bus.wr_en   = wr_en_reg;
  assign bus.wr_addr = wr_addr_reg;
  assign bus.wr_data = wr_data_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

`ifdef FETCH_BEAT_CHECK_EN
  // Counter is wide enough to see one burst plus an overrun before wrapping.
  localparam int BC_W = MAX_BURST_CODE + 2;

  logic [BC_W-1:0] beat_cnt_reg, beat_cnt_next, beat_cnt_inc, len_bc;
  logic            err_reg, err_next;

  assign beat_cnt_inc = beat_cnt_reg + BC_W'(1);
  assign len_bc       = BC_W'(len_reg);

  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    err_next      = err_reg;
    if (start_acc) begin
      beat_cnt_next = '0;
      err_next      = 1'b0;
    end else if (ar_hs) begin
      beat_cnt_next = '0;
    end else if (beat) begin
      beat_cnt_next = beat_cnt_inc;
      if (bus.rlast ? (beat_cnt_inc != len_bc) : (beat_cnt_inc >= len_bc)) err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_next;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ifm_fetch_ctrl.sv
// Scoreboard bench for ifm_fetch_ctrl: a memory-slave model answers read bursts with
// data = address; a negedge monitor checks requests, buffer writes and done against queues.
module tb_ifm_fetch_ctrl;

  typedef struct packed { logic [31:0] addr; logic [3:0] code; } ar_t;
  typedef struct packed { logic [9:0] addr; logic [31:0] data; } wr_t;

`ifdef FETCH_BEAT_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [23:0] total_words = '0;
  logic        busy, done, err;

  ifm_fetch_ctrl_if #(.DW(32), .AW(32), .BUF_AW(10)) bus ();

  ifm_fetch_ctrl #(
    .DW(32), .AW(32), .CNT_W(24), .BUF_AW(10), .MAX_BURST_CODE(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .total_words(total_words),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int  tests = 0, failed = 0;
  int  done_seen = 0, wr_seen = 0;
  ar_t exp_ar[$];
  wr_t exp_wr[$];
  bit  exp_done[$];

  // slave model state and knobs
  int          ar_stall_cfg = 0, short_last = -1;
  bit          s_serving = 0;
  logic [31:0] s_addr = '0, ara_s = '0;
  logic [3:0]  arb_s = '0;
  logic        arv_s = 1'b0, prev_wr = 1'b0;
  int          s_len = 0, s_idx = 0, s_stall = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("FAIL %s: output seen with nothing expected", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_burst(input logic [31:0] a, input int code, input int nbeats, input int wptr0);
    ar_t ea;
    wr_t ew;
    ea.addr = a;
    ea.code = 4'(code);
    exp_ar.push_back(ea);
    for (int i = 0; i < nbeats; i++) begin
      ew.addr = 10'(wptr0 + i);
      ew.data = a + 32'(i);
      exp_wr.push_back(ew);
    end
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [23:0] n);
    base_addr   = b;
    total_words = n;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int d0;
    bit got;
    d0  = done_seen;
    got = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done_seen > d0) begin
        got = 1;
        break;
      end
    end
    tests++;
    if (!got) begin
      failed++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, bound);
    end
  endtask

  // Memory slave: arready after ar_stall_cfg cycles of arvalid, then one beat per cycle.
  initial begin : slave
    bus.arready   = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rlast     = 1'b0;
    bus.rdata     = '0;
    bus.buf_space = 11'd1024;
    forever begin
      @(negedge clk);
      arv_s = bus.arvalid;
      ara_s = bus.araddr;
      arb_s = bus.arburst;
      @(posedge clk);
      #1;
      if (rst) begin
        s_serving   = 0;
        s_stall     = 0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
      end else begin
        if (bus.rvalid) begin
          if (bus.rlast) s_serving = 0;
          else s_idx++;
        end
        if (arv_s && bus.arready) begin
          s_serving = 1;
          s_addr    = ara_s;
          s_len     = 1 << arb_s;
          s_idx     = 0;
        end
        bus.rvalid = s_serving;
        bus.rdata  = s_addr + 32'(s_idx);
        bus.rlast  = s_serving && ((s_idx == s_len - 1) || (s_idx == short_last));
        if (bus.arvalid) begin
          if (s_stall >= ar_stall_cfg) bus.arready = 1'b1;
          else begin
            bus.arready = 1'b0;
            s_stall++;
          end
        end else begin
          bus.arready = 1'b0;
          s_stall     = 0;
        end
      end
    end
  end

  initial begin : monitor
    ar_t ea;
    wr_t ew;
    bit  ed;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wr = 1'b0;
        continue;
      end
      if (bus.arvalid && bus.arready) begin
        if (exp_ar.size() == 0) fail_now("ar_unexpected");
        else begin
          ea = exp_ar.pop_front();
          chk("ar_addr_code", {bus.araddr, bus.arburst}, {ea.addr, ea.code});
        end
      end
      if (bus.wr_en) begin
        wr_seen++;
        if (exp_wr.size() == 0) fail_now("wr_unexpected");
        else begin
          ew = exp_wr.pop_front();
          chk("wr_addr_data", {bus.wr_addr, bus.wr_data}, {ew.addr, ew.data});
        end
      end
      if (done) begin
        done_seen++;
        if (exp_done.size() == 0) fail_now("done_unexpected");
        else begin
          ed = exp_done.pop_front();
          chk("done_after_last_write", prev_wr, ed);
          chk("done_writes_drained", exp_wr.size(), 0);
          chk("done_busy_low", busy, 0);
        end
      end
      prev_wr = bus.wr_en;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish expected finish by 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w;
    int stalls;

    // reset state
    repeat (3) tick();
    chk("reset_outputs", {busy, done, err, bus.arvalid, bus.arburst, bus.araddr,
                          bus.wr_en, bus.wr_addr, bus.wr_data}, '0);
    rst = 1'b0;
    tick();

    // single burst and start-to-arvalid latency
    exp_burst(32'h100, 4, 16, 0);
    exp_done.push_back(1'b1);
    pulse_start(32'h100, 24'd16);
    chk("start_busy", busy, 1);
    chk("plan_arvalid_low", bus.arvalid, 0);
    tick();
    chk("req_arvalid_high", bus.arvalid, 1);
    wait_done("single", 200);
    chk("single_err_clear", err, 0);

    // tail split, with a start pulse while busy that must be ignored
    exp_burst(32'h200, 4, 16, 0);
    exp_burst(32'h210, 2, 4, 16);
    exp_burst(32'h214, 0, 1, 20);
    exp_done.push_back(1'b1);
    pulse_start(32'h200, 24'd21);
    repeat (3) tick();
    pulse_start(32'hDEAD_0000, 24'd5);
    wait_done("tail", 300);

    // zero-length command
    exp_done.push_back(1'b0);
    pulse_start(32'h900, 24'd0);
    chk("zero_busy", busy, 1);
    wait_done("zero", 20);

    // buffer-space gating
    bus.buf_space = 11'd8;
    exp_burst(32'h700, 4, 16, 0);
    exp_done.push_back(1'b1);
    pulse_start(32'h700, 24'd16);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("gate_arvalid_low", bus.arvalid, 0);
    end
    bus.buf_space = 11'd16;
    tick();
    chk("gate_arvalid_rise", bus.arvalid, 1);
    wait_done("gate", 200);
    bus.buf_space = 11'd1024;

    // slave stall: request held steady for 5 cycles
    ar_stall_cfg = 5;
    stalls = 0;
    exp_burst(32'h800, 3, 8, 0);
    exp_done.push_back(1'b1);
    pulse_start(32'h800, 24'd8);
    tick();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_req_held", {bus.arvalid, bus.araddr, bus.arburst}, {1'b1, 32'h800, 4'd3});
      if (bus.arready) break;
      stalls++;
    end
    chk("stall_cycles", stalls, 5);
    tick();
    chk("stall_arvalid_drop", bus.arvalid, 0);
    wait_done("stall", 200);
    ar_stall_cfg = 0;

    // address wrap modulo 2^32
    exp_burst(32'hFFFF_FFF8, 4, 16, 0);
    exp_burst(32'h0000_0008, 2, 4, 16);
    exp_done.push_back(1'b1);
    pulse_start(32'hFFFF_FFF8, 24'd20);
    wait_done("addr_wrap", 300);

    // buffer write address wraps past 1023
    w = 0;
    for (int b = 0; b < 64; b++) begin
      exp_burst(32'h1000 + 32'(16 * b), 4, 16, w);
      w += 16;
    end
    exp_burst(32'h1400, 2, 4, w);
    w += 4;
    exp_burst(32'h1404, 1, 2, w);
    exp_done.push_back(1'b1);
    pulse_start(32'h1000, 24'd1030);
    wait_done("wr_wrap", 4000);

    // asynchronous reset in the middle of a burst
    exp_burst(32'h300, 4, 16, 0);
    exp_done.push_back(1'b1);
    w = wr_seen;
    pulse_start(32'h300, 24'd16);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wr_seen - w >= 3) break;
    end
    chk("rst_beats_seen", (wr_seen - w >= 3), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {busy, done, err, bus.arvalid, bus.arburst, bus.araddr,
                              bus.wr_en, bus.wr_addr, bus.wr_data}, '0);
    exp_ar.delete();
    exp_wr.delete();
    exp_done.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_burst(32'h400, 2, 4, 0);
    exp_done.push_back(1'b1);
    pulse_start(32'h400, 24'd4);
    wait_done("after_rst", 100);

    // early rlast: 3 beats of a 4-beat burst
    short_last = 2;
    exp_burst(32'h500, 2, 3, 0);
    exp_done.push_back(1'b1);
    pulse_start(32'h500, 24'd4);
    wait_done("short", 100);
    short_last = -1;
    chk("err_after_short", err, ERR_EXP);
    repeat (3) tick();
    chk("err_sticky", err, ERR_EXP);
    exp_burst(32'h600, 0, 1, 0);
    exp_done.push_back(1'b1);
    pulse_start(32'h600, 24'd1);
    chk("err_cleared_by_start", err, 0);
    wait_done("after_err", 100);

    repeat (3) tick();
    chk("queues_empty", {32'(exp_ar.size()), 32'(exp_wr.size()), 32'(exp_done.size())}, '0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
